// File: rtl/rng_hist.sv
// Statistics stage behind the 8-bit rng: windowed histogram of the sample MSBs plus first-repeat period.
// The sample input is called rand_in because "rand" is a reserved word in SystemVerilog.
module rng_hist #(
    parameter int DATA_W   = 8,
    parameter int BIN_BITS = 4,
    parameter int CNT_W    = 16,
    parameter int WINDOW   = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   rand_in,
    input  logic                sample_en,
    input  logic                start,
    input  logic [BIN_BITS-1:0] rd_addr,
    output logic [CNT_W-1:0]    rd_data,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   first_val,
    output logic [CNT_W-1:0]    period,
    output logic                period_valid
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam int               NBINS    = 1 << BIN_BITS;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    sample_cnt_q, sample_cnt_d;
    logic [DATA_W-1:0]   first_val_q, first_val_d;
    logic [CNT_W-1:0]    period_q, period_d;
    logic                period_valid_q, period_valid_d;
    logic [CNT_W-1:0]    rd_data_q, rd_data_d;

    logic [NBINS-1:0][CNT_W-1:0] bin_vec;
    logic                        clear;
    logic                        accept;
    logic [BIN_BITS-1:0]         bin_idx;

    assign clear   = (state_q != S_COLLECT) && start;
    assign accept  = (state_q == S_COLLECT) && sample_en;
    assign bin_idx = rand_in[DATA_W-1 -: BIN_BITS];

    always_comb begin
        state_d        = state_q;
        sample_cnt_d   = sample_cnt_q;
        first_val_d    = first_val_q;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        if (clear) begin
            state_d        = S_COLLECT;
            sample_cnt_d   = '0;
            first_val_d    = '0;
            period_d       = '0;
            period_valid_d = 1'b0;
        end else if (accept) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
            // sample_cnt_q is the index of the sample being accepted
            if (sample_cnt_q == '0) begin
                first_val_d = rand_in;
            end else if (!period_valid_q && (rand_in == first_val_q)) begin
                period_d       = sample_cnt_q;
                period_valid_d = 1'b1;
            end
            if (sample_cnt_q == LAST_IDX) begin
                state_d = S_DONE;
            end
        end
    end

    // Read port sees the count before any same-cycle increment
    always_comb begin
        rd_data_d = bin_vec[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            sample_cnt_q   <= '0;
            first_val_q    <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            sample_cnt_q   <= sample_cnt_d;
            first_val_q    <= first_val_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            rd_data_q      <= rd_data_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NBINS; gi++) begin : g_bin
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clear) begin
                    cnt_d = '0;
                end else if (accept && (bin_idx == BIN_BITS'(gi)) && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign bin_vec[gi] = cnt_q;
        end
    endgenerate

    assign rd_data      = rd_data_q;
    assign busy         = (state_q == S_COLLECT);
    assign done         = (state_q == S_DONE);
    assign first_val    = first_val_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
endmodule

// File: tb/tb_rng_hist.sv
// Directed bench for rng_hist: table of full-window runs plus hand sequences for
// mid-run start, mid-run reset and a narrow-counter instance.
module tb_rng_hist;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rand_in;
    logic        sample_en;
    logic        start;
    logic [3:0]  rd_addr;

    logic [15:0] rd_data, period;
    logic        busy, done, period_valid;
    logic [7:0]  first_val;

    logic [3:0]  s_rd_data, s_period;
    logic        s_busy, s_done, s_period_valid;
    logic [7:0]  s_first_val;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rng_hist dut (
        .clk(clk), .rst_n(rst_n), .rand_in(rand_in), .sample_en(sample_en),
        .start(start), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .done(done), .first_val(first_val), .period(period),
        .period_valid(period_valid)
    );

    rng_hist #(.CNT_W(4), .WINDOW(15)) dut_small (
        .clk(clk), .rst_n(rst_n), .rand_in(rand_in), .sample_en(sample_en),
        .start(start), .rd_addr(rd_addr), .rd_data(s_rd_data), .busy(s_busy),
        .done(s_done), .first_val(s_first_val), .period(s_period),
        .period_valid(s_period_valid)
    );

    typedef struct {
        int                 mode;      // 0 constant, 1 ramp, 2 three-value cycle
        logic [7:0]         base;
        bit                 toggle;    // sample_en alternates 1/0
        logic [15:0][15:0]  exp_bins;
        logic [7:0]         exp_first;
        logic [15:0]        exp_period;
        logic               exp_pv;
        int                 exp_cycles;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gen(input int mode, input logic [7:0] base, input int k);
        logic [7:0] v;
        case (mode)
            1:       v = 8'(k);
            2:       v = 8'(8'h10 * ((k % 3) + 1));
            default: v = base;
        endcase
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start     = 1'b1;
        sample_en = 1'b0;
        step();
        start     = 1'b0;
    endtask

    // Feeds samples until n are accepted; returns cycles used, -1 on timeout
    task automatic feed(input int mode, input logic [7:0] base, input bit toggle,
                        input int n, output int cycles);
        int k = 0;
        cycles = 0;
        while (k < n && cycles < 2000) begin
            rand_in   = gen(mode, base, k);
            sample_en = toggle ? (cycles % 2 == 0) : 1'b1;
            step();
            if (sample_en) k++;
            cycles++;
        end
        sample_en = 1'b0;
        if (k < n) cycles = -1;
    endtask

    initial begin
        int cyc;

        vecs[0].mode = 0; vecs[0].base = 8'h35; vecs[0].toggle = 1'b0;
        vecs[0].exp_bins = '0; vecs[0].exp_bins[3] = 16'd255;
        vecs[0].exp_first = 8'h35; vecs[0].exp_period = 16'd1; vecs[0].exp_pv = 1'b1;
        vecs[0].exp_cycles = 255;

        vecs[1].mode = 1; vecs[1].base = 8'h00; vecs[1].toggle = 1'b0;
        for (int b = 0; b < 15; b++) vecs[1].exp_bins[b] = 16'd16;
        vecs[1].exp_bins[15] = 16'd15;
        vecs[1].exp_first = 8'h00; vecs[1].exp_period = 16'd0; vecs[1].exp_pv = 1'b0;
        vecs[1].exp_cycles = 255;

        vecs[2].mode = 2; vecs[2].base = 8'h00; vecs[2].toggle = 1'b0;
        vecs[2].exp_bins = '0;
        vecs[2].exp_bins[1] = 16'd85; vecs[2].exp_bins[2] = 16'd85; vecs[2].exp_bins[3] = 16'd85;
        vecs[2].exp_first = 8'h10; vecs[2].exp_period = 16'd3; vecs[2].exp_pv = 1'b1;
        vecs[2].exp_cycles = 255;

        vecs[3] = vecs[0];
        vecs[3].toggle = 1'b1;
        vecs[3].exp_cycles = 509;

        rst_n = 1'b0; rand_in = '0; sample_en = 1'b0; start = 1'b0; rd_addr = '0;
        step(); step();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset first_val", 32'(first_val), 32'd0);
        chk("reset period", 32'(period), 32'd0);
        chk("reset period_valid", 32'(period_valid), 32'd0);
        chk("reset rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle rd_data", 32'(rd_data), 32'd0);

        for (int v = 0; v < 4; v++) begin
            pulse_start();
            chk($sformatf("v%0d busy after start", v), 32'(busy), 32'd1);
            chk($sformatf("v%0d done after start", v), 32'(done), 32'd0);
            feed(vecs[v].mode, vecs[v].base, vecs[v].toggle, 255, cyc);
            chk($sformatf("v%0d cycles", v), 32'(cyc), 32'(vecs[v].exp_cycles));
            chk($sformatf("v%0d done", v), 32'(done), 32'd1);
            chk($sformatf("v%0d busy", v), 32'(busy), 32'd0);
            chk($sformatf("v%0d first_val", v), 32'(first_val), 32'(vecs[v].exp_first));
            chk($sformatf("v%0d period", v), 32'(period), 32'(vecs[v].exp_period));
            chk($sformatf("v%0d period_valid", v), 32'(period_valid), 32'(vecs[v].exp_pv));
            for (int b = 0; b < 16; b++) begin
                rd_addr = 4'(b);
                step();
                chk($sformatf("v%0d bin%0d", v, b), 32'(rd_data), 32'(vecs[v].exp_bins[b]));
            end
            chk($sformatf("v%0d done hold", v), 32'(done), 32'd1);
            $display("vector %0d complete: first_val=%0h period=%0d valid=%0d", v, first_val, period, period_valid);
        end

        // start while collecting must be ignored; the sample in that cycle still counts
        pulse_start();
        feed(0, 8'h35, 1'b0, 100, cyc);
        start = 1'b1;
        feed(0, 8'h35, 1'b0, 1, cyc);
        start = 1'b0;
        chk("midstart busy", 32'(busy), 32'd1);
        feed(0, 8'h35, 1'b0, 154, cyc);
        chk("midstart done", 32'(done), 32'd1);
        rd_addr = 4'd3;
        step();
        chk("midstart bin3", 32'(rd_data), 32'd255);
        chk("midstart period", 32'(period), 32'd1);
        $display("mid-run start sequence complete");

        // reset mid-run drops everything collected so far
        pulse_start();
        feed(2, 8'h00, 1'b0, 50, cyc);
        rd_addr = 4'd1;
        step();
        chk("prereset bin1 live", 32'(rd_data), 32'd17);
        rst_n = 1'b0;
        step();
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst first_val", 32'(first_val), 32'd0);
        chk("midrst period", 32'(period), 32'd0);
        chk("midrst period_valid", 32'(period_valid), 32'd0);
        chk("midrst rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        step();
        chk("postrst bin1", 32'(rd_data), 32'd0);
        feed(0, 8'h35, 1'b0, 3, cyc);
        chk("postrst idle ignores samples", 32'(busy), 32'd0);
        step();
        chk("postrst bin1 still 0", 32'(rd_data), 32'd0);
        $display("mid-run reset sequence complete");

        // narrow instance: 4-bit counters, 15-sample window
        pulse_start();
        chk("small busy", 32'(s_busy), 32'd1);
        feed(0, 8'hF0, 1'b0, 14, cyc);
        chk("small not done early", 32'(s_done), 32'd0);
        feed(0, 8'hF0, 1'b0, 1, cyc);
        chk("small done", 32'(s_done), 32'd1);
        chk("small first_val", 32'(s_first_val), 32'hF0);
        chk("small period", 32'(s_period), 32'd1);
        rd_addr = 4'd15;
        step();
        chk("small bin15", 32'(s_rd_data), 32'd15);
        rd_addr = 4'd14;
        step();
        chk("small bin14", 32'(s_rd_data), 32'd0);
        $display("narrow instance sequence complete");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
